// File: rtl/ga_issue_queue.sv
// In-order request buffer and single-outstanding issue sequencer in front of ga_coprocessor.
// Optional response watchdog enabled by defining GA_ISSUE_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | waiting for a queued request; pops the FIFO head into the issue register
// S_ISSUE | presenting the issue register to the coprocessor
// S_WAIT  | issue accepted, waiting for the coprocessor result
// S_RESP  | presenting the captured result to the core
module ga_issue_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [3:0]                   req_funct_i,
    input  logic [31:0]                  req_op_a_i,
    input  logic [31:0]                  req_op_b_i,
    input  logic [4:0]                   req_rd_i,
    input  logic                         flush_i,
    output logic                         cp_valid_o,
    input  logic                         cp_ready_i,
    output logic [3:0]                   cp_funct_o,
    output logic [31:0]                  cp_op_a_o,
    output logic [31:0]                  cp_op_b_o,
    input  logic                         cp_resp_valid_i,
    input  logic [31:0]                  cp_result_i,
    input  logic                         cp_error_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [31:0]                  rsp_result_o,
    output logic [4:0]                   rsp_rd_o,
    output logic                         rsp_error_o,
    output logic                         rsp_timeout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    typedef struct packed {
        logic [3:0]  funct;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
    } entry_t;

    state_e        state_q, state_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        iss_q, iss_d;
    logic          cp_valid_q, cp_valid_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_result_q, rsp_result_d;
    logic          rsp_error_q, rsp_error_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic [15:0]   wait_cnt_q, wait_cnt_d;

    logic full, empty, push, pop, wait_last, timeout_hit;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign req_ready_o = !full && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state_q == S_IDLE) && !empty && !flush_i;
    // The counter parks at its last value; only the watchdog build acts on it.
    assign wait_last   = (wait_cnt_q == TIMEOUT_LAST);

`ifdef GA_ISSUE_TIMEOUT_EN
    assign timeout_hit = wait_last;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        iss_d         = iss_q;
        cp_valid_d    = cp_valid_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{funct: req_funct_i, op_a: req_op_a_i,
                                op_b: req_op_b_i, rd: req_rd_i};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            iss_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d    = S_ISSUE;
                    cp_valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cp_ready_i) begin
                    state_d    = S_WAIT;
                    cp_valid_d = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (cp_resp_valid_i) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = cp_result_i;
                    rsp_error_d   = cp_error_i;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_result_d  = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (!wait_last) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            iss_q         <= '0;
            cp_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            iss_q         <= iss_d;
            cp_valid_q    <= cp_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign cp_valid_o    = cp_valid_q;
    assign cp_funct_o    = iss_q.funct;
    assign cp_op_a_o     = iss_q.op_a;
    assign cp_op_b_o     = iss_q.op_b;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_result_o  = rsp_result_q;
    // The issue register is only reloaded from IDLE, so rd stays valid through RESP.
    assign rsp_rd_o      = iss_q.rd;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign count_o       = count_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ga_issue_queue.sv
// Self-checking bench for ga_issue_queue (DEPTH=4, TIMEOUT_CYCLES=20); the timeout scenario
// follows whether GA_ISSUE_TIMEOUT_EN is defined for the build.
module tb_ga_issue_queue;

    localparam int DEPTH = 4;
    localparam int TO    = 20;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o;
    logic [3:0]    req_funct_i;
    logic [31:0]   req_op_a_i, req_op_b_i;
    logic [4:0]    req_rd_i;
    logic          flush_i;
    logic          cp_valid_o, cp_ready_i;
    logic [3:0]    cp_funct_o;
    logic [31:0]   cp_op_a_o, cp_op_b_o;
    logic          cp_resp_valid_i;
    logic [31:0]   cp_result_i;
    logic          cp_error_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [31:0]   rsp_result_o;
    logic [4:0]    rsp_rd_o;
    logic          rsp_error_o, rsp_timeout_o;
    logic [CW-1:0] count_o;
    logic          busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } req_t;

    ga_issue_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct_i(req_funct_i), .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
        .req_rd_i(req_rd_i), .flush_i(flush_i),
        .cp_valid_o(cp_valid_o), .cp_ready_i(cp_ready_i), .cp_funct_o(cp_funct_o),
        .cp_op_a_o(cp_op_a_o), .cp_op_b_o(cp_op_b_o),
        .cp_resp_valid_i(cp_resp_valid_i), .cp_result_i(cp_result_i), .cp_error_i(cp_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .rsp_rd_o(rsp_rd_o), .rsp_error_o(rsp_error_o), .rsp_timeout_o(rsp_timeout_o),
        .count_o(count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic req_t rand_req();
        req_t r;
        r.f  = 4'($urandom_range(0, 15));
        r.a  = $urandom;
        r.b  = $urandom;
        r.rd = 5'($urandom_range(0, 31));
        return r;
    endfunction

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input req_t r, input logic v);
        req_valid_i = v;
        req_funct_i = r.f;
        req_op_a_i  = r.a;
        req_op_b_i  = r.b;
        req_rd_i    = r.rd;
    endtask

    task automatic push_one(input req_t r);
        drive_req(r, 1'b1);
        step();
        req_valid_i = 1'b0;
    endtask

    // Coprocessor + core side for one transaction; expects r to be the next issue.
    task automatic serve(input req_t r, input logic [31:0] res, input logic err, input int dly);
        int w = 0;
        while (!cp_valid_o && w < 50) begin
            step();
            w++;
        end
        n_checks++;
        if (!cp_valid_o) $display("FAIL serve_issue: cp_valid got 0 want 1 within 50 cycles");
        else n_pass++;
        n_checks++;
        if ({cp_funct_o, cp_op_a_o, cp_op_b_o} !== {r.f, r.a, r.b})
            $display("FAIL serve_payload: got %h_%h_%h want %h_%h_%h",
                     cp_funct_o, cp_op_a_o, cp_op_b_o, r.f, r.a, r.b);
        else n_pass++;
        cp_ready_i = 1'b1;
        step();
        cp_ready_i = 1'b0;
        repeat (dly) step();
        cp_resp_valid_i = 1'b1;
        cp_result_i     = res;
        cp_error_i      = err;
        step();
        cp_resp_valid_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !==
            {1'b1, res, r.rd, err, 1'b0})
            $display("FAIL serve_rsp: got v%b %h rd%0d e%b t%b want v1 %h rd%0d e%b t0",
                     rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o,
                     res, r.rd, err);
        else n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if ({req_ready_o, cp_valid_o, rsp_valid_o, busy_o} !== 4'b1000)
            $display("FAIL reset_ctrl: got rdy%b cpv%b rspv%b busy%b want 1 0 0 0",
                     req_ready_o, cp_valid_o, rsp_valid_o, busy_o);
        else n_pass++;
        n_checks++;
        if (count_o !== '0) $display("FAIL reset_count: got %0d want 0", count_o);
        else n_pass++;
        n_checks++;
        if ({cp_funct_o, cp_op_a_o, cp_op_b_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !== '0)
            $display("FAIL reset_data: got %h %h %h %h %h %b %b want all zero", cp_funct_o,
                     cp_op_a_o, cp_op_b_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o);
        else n_pass++;
        rst_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, cp_valid_o, count_o} !== '0)
            $display("FAIL reset_release: got busy%b cpv%b cnt%0d want 0 0 0", busy_o, cp_valid_o, count_o);
        else n_pass++;
    endtask

    task automatic test_single();
        req_t r = '{f: 4'd0, a: 32'h3, b: 32'h5, rd: 5'd7};
        cp_ready_i = 1'b1;
        drive_req(r, 1'b1);
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) $display("FAIL single_ready: got %b want 1", req_ready_o);
        else n_pass++;
        step();                       // cycle N+1
        req_valid_i = 1'b0;
        n_checks++;
        if ({cp_valid_o, count_o} !== {1'b0, CW'(1)})
            $display("FAIL single_n1: got cpv%b cnt%0d want cpv0 cnt1", cp_valid_o, count_o);
        else n_pass++;
        step();                       // cycle N+2
        n_checks++;
        if ({cp_valid_o, cp_funct_o, cp_op_a_o, cp_op_b_o} !== {1'b1, 4'd0, 32'h3, 32'h5})
            $display("FAIL single_issue: got v%b %h %h %h want v1 0 3 5",
                     cp_valid_o, cp_funct_o, cp_op_a_o, cp_op_b_o);
        else n_pass++;
        step();                       // first WAIT cycle
        cp_ready_i = 1'b0;
        step();
        step();
        cp_resp_valid_i = 1'b1;       // result in cycle M
        cp_result_i     = 32'h8;
        cp_error_i      = 1'b0;
        step();                       // M+1
        cp_resp_valid_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !==
            {1'b1, 32'h8, 5'd7, 1'b0, 1'b0})
            $display("FAIL single_rsp: got v%b %h rd%0d e%b t%b want v1 8 rd7 e0 t0",
                     rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o);
        else n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00)
            $display("FAIL single_done: got rspv%b busy%b want 0 0", rsp_valid_o, busy_o);
        else n_pass++;
    endtask

    task automatic test_full();
        req_t reqs [6];
        int   idx = 0;
        logic acc;
        foreach (reqs[i]) reqs[i] = rand_req();
        cp_ready_i = 1'b0;
        repeat (10) begin
            if (idx < 6) drive_req(reqs[idx], 1'b1);
            #1;
            acc = req_valid_i && req_ready_o;
            step();
            if (acc) idx++;
        end
        n_checks++;
        if (idx !== 5) $display("FAIL full_accepted: got %0d want 5", idx);
        else n_pass++;
        n_checks++;
        if ({count_o, req_ready_o, cp_valid_o} !== {CW'(DEPTH), 1'b0, 1'b1})
            $display("FAIL full_state: got cnt%0d rdy%b cpv%b want cnt4 rdy0 cpv1",
                     count_o, req_ready_o, cp_valid_o);
        else n_pass++;
        req_valid_i = 1'b0;
        for (int i = 0; i < 5; i++)
            serve(reqs[i], reqs[i].a ^ reqs[i].b, (i == 2), $urandom_range(0, 3));
        step();
        n_checks++;
        if ({busy_o, count_o, cp_valid_o} !== '0)
            $display("FAIL full_drained: got busy%b cnt%0d cpv%b want 0 0 0", busy_o, count_o, cp_valid_o);
        else n_pass++;
    endtask

    task automatic test_rsp_hold();
        req_t r0 = rand_req();
        req_t r1 = rand_req();
        int   w  = 0;
        logic bad;
        push_one(r0);
        push_one(r1);
        while (!cp_valid_o && w < 20) begin
            step();
            w++;
        end
        cp_ready_i = 1'b1;
        step();
        cp_ready_i      = 1'b0;
        cp_resp_valid_i = 1'b1;
        cp_result_i     = 32'hCAFE_0001;
        cp_error_i      = 1'b1;
        step();
        cp_resp_valid_i = 1'b0;
        cp_result_i     = 32'h0;
        cp_error_i      = 1'b0;
        rsp_ready_i     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bad = ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o} !== {1'b1, 32'hCAFE_0001, r0.rd, 1'b1});
            n_checks++;
            if (bad) $display("FAIL hold_rsp_%0d: got v%b %h rd%0d e%b want v1 cafe0001 rd%0d e1",
                              k, rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, r0.rd);
            else n_pass++;
            n_checks++;
            if ({cp_valid_o, count_o} !== {1'b0, CW'(1)})
                $display("FAIL hold_queue_%0d: got cpv%b cnt%0d want cpv0 cnt1", k, cp_valid_o, count_o);
            else n_pass++;
            step();
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        serve(r1, 32'h1234_5678, 1'b0, 1);
    endtask

    task automatic test_flush();
        req_t r [5];
        foreach (r[i]) r[i] = rand_req();
        cp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(r[i], 1'b1);
            step();
        end
        req_valid_i = 1'b0;
        cp_ready_i  = 1'b0;
        n_checks++;
        if ({count_o, busy_o, cp_valid_o} !== {CW'(3), 1'b1, 1'b0})
            $display("FAIL flush_pre: got cnt%0d busy%b cpv%b want cnt3 busy1 cpv0", count_o, busy_o, cp_valid_o);
        else n_pass++;
        flush_i = 1'b1;
        drive_req(r[4], 1'b1);
        #1;
        n_checks++;
        if (req_ready_o !== 1'b0) $display("FAIL flush_ready: got %b want 0", req_ready_o);
        else n_pass++;
        step();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        n_checks++;
        if (count_o !== '0) $display("FAIL flush_count: got %0d want 0", count_o);
        else n_pass++;
        cp_resp_valid_i = 1'b1;
        cp_result_i     = 32'h0BAD_F00D;
        cp_error_i      = 1'b0;
        step();
        cp_resp_valid_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_rd_o} !== {1'b1, 32'h0BAD_F00D, r[0].rd})
            $display("FAIL flush_inflight: got v%b %h rd%0d want v1 0badf00d rd%0d",
                     rsp_valid_o, rsp_result_o, rsp_rd_o, r[0].rd);
        else n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({cp_valid_o, busy_o, count_o} !== '0)
                $display("FAIL flush_quiet_%0d: got cpv%b busy%b cnt%0d want 0 0 0", k, cp_valid_o, busy_o, count_o);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_timeout();
        req_t r = rand_req();
        int   early = 0;
        push_one(r);
        step();
        cp_ready_i = 1'b1;
        step();
        cp_ready_i = 1'b0;            // first WAIT cycle
`ifdef GA_ISSUE_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            if (rsp_valid_o) early++;
            step();
        end
        n_checks++;
        if (early != 0) $display("FAIL to_early: got %0d early rsp cycles want 0", early);
        else n_pass++;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !==
            {1'b1, 32'h0, r.rd, 1'b1, 1'b1})
            $display("FAIL to_rsp: got v%b %h rd%0d e%b t%b want v1 0 rd%0d e1 t1",
                     rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o, r.rd);
        else n_pass++;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i     = 1'b0;
        cp_resp_valid_i = 1'b1;       // late response while idle
        cp_result_i     = 32'hDEAD_BEEF;
        step();
        step();
        cp_resp_valid_i = 1'b0;
        step();
        n_checks++;
        if ({rsp_valid_o, busy_o} !== 2'b00)
            $display("FAIL to_late_ignored: got rspv%b busy%b want 0 0", rsp_valid_o, busy_o);
        else n_pass++;
        // A response in the final allowed WAIT cycle beats the watchdog.
        r = rand_req();
        push_one(r);
        step();
        cp_ready_i = 1'b1;
        step();
        cp_ready_i = 1'b0;
        early = 0;
        for (int k = 0; k < TO - 1; k++) begin
            if (rsp_valid_o) early++;
            step();
        end
        cp_resp_valid_i = 1'b1;
        cp_result_i     = 32'h0000_1234;
        cp_error_i      = 1'b0;
        step();
        cp_resp_valid_i = 1'b0;
        n_checks++;
        if (early != 0) $display("FAIL to_race_early: got %0d early rsp cycles want 0", early);
        else n_pass++;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_error_o, rsp_timeout_o} !== {1'b1, 32'h1234, 1'b0, 1'b0})
            $display("FAIL to_race: got v%b %h e%b t%b want v1 1234 e0 t0",
                     rsp_valid_o, rsp_result_o, rsp_error_o, rsp_timeout_o);
        else n_pass++;
`else
        for (int k = 0; k < 3 * TO; k++) begin
            if (rsp_valid_o) early++;
            step();
        end
        n_checks++;
        if (early != 0) $display("FAIL nowd_wait: got %0d rsp cycles want 0", early);
        else n_pass++;
        cp_resp_valid_i = 1'b1;
        cp_result_i     = 32'h0000_1234;
        cp_error_i      = 1'b0;
        step();
        cp_resp_valid_i = 1'b0;
        n_checks++;
        if ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !==
            {1'b1, 32'h1234, r.rd, 1'b0, 1'b0})
            $display("FAIL nowd_rsp: got v%b %h rd%0d e%b t%b want v1 1234 rd%0d e0 t0",
                     rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o, r.rd);
        else n_pass++;
`endif
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_random();
        req_t        exp_q [$];
        req_t        cur, nxt;
        bit          in_issue = 0, in_wait = 0, want_rsp = 0, pushed = 0, exp_ready;
        int          wdly = 0, cyc = 0, accepted = 0, responded = 0;
        logic [31:0] exp_res = '0;
        logic        exp_err = 1'b0;
        cur = '0;
        nxt = '0;
        while (cyc < 3000 && !(cyc >= 500 && exp_q.size() == 0 && !in_issue && !in_wait && !want_rsp && !pushed)) begin
            step();
            cyc++;
            if (pushed) exp_q.push_back(nxt);
            pushed = 0;
            if (cp_valid_o && !in_issue) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rnd_issue: got unexpected issue want none (cycle %0d)", cyc);
                else begin
                    cur = exp_q.pop_front();
                    if ({cp_funct_o, cp_op_a_o, cp_op_b_o} !== {cur.f, cur.a, cur.b})
                        $display("FAIL rnd_issue: got %h_%h_%h want %h_%h_%h",
                                 cp_funct_o, cp_op_a_o, cp_op_b_o, cur.f, cur.a, cur.b);
                    else n_pass++;
                end
                in_issue = 1;
            end else if (in_issue) begin
                n_checks++;
                if ({cp_valid_o, cp_funct_o, cp_op_a_o, cp_op_b_o} !== {1'b1, cur.f, cur.a, cur.b})
                    $display("FAIL rnd_issue_hold: got v%b %h_%h_%h want v1 %h_%h_%h",
                             cp_valid_o, cp_funct_o, cp_op_a_o, cp_op_b_o, cur.f, cur.a, cur.b);
                else n_pass++;
            end
            n_checks++;
            if (count_o !== CW'(exp_q.size()))
                $display("FAIL rnd_count: got %0d want %0d (cycle %0d)", count_o, exp_q.size(), cyc);
            else n_pass++;
            n_checks++;
            if (want_rsp) begin
                if ({rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o} !==
                    {1'b1, exp_res, cur.rd, exp_err, 1'b0})
                    $display("FAIL rnd_rsp: got v%b %h rd%0d e%b t%b want v1 %h rd%0d e%b t0",
                             rsp_valid_o, rsp_result_o, rsp_rd_o, rsp_error_o, rsp_timeout_o,
                             exp_res, cur.rd, exp_err);
                else n_pass++;
            end else begin
                if (rsp_valid_o !== 1'b0) $display("FAIL rnd_rsp_idle: got rspv %b want 0", rsp_valid_o);
                else n_pass++;
            end

            exp_ready = (exp_q.size() < DEPTH);
            n_checks++;
            if (req_ready_o !== exp_ready) $display("FAIL rnd_ready: got %b want %b", req_ready_o, exp_ready);
            else n_pass++;
            nxt = rand_req();
            drive_req(nxt, (cyc < 500) && ($urandom_range(0, 1) == 1));
            if (req_valid_i && exp_ready) begin
                pushed = 1;
                accepted++;
            end

            rsp_ready_i = ($urandom_range(0, 1) == 1);
            if (want_rsp && rsp_ready_i) begin
                want_rsp = 0;
                responded++;
            end

            cp_result_i = $urandom;
            cp_error_i  = ($urandom_range(0, 3) == 0);
            if (in_wait) begin
                cp_resp_valid_i = (wdly == 0);
                if (wdly == 0) begin
                    in_wait  = 0;
                    want_rsp = 1;
                    exp_res  = cp_result_i;
                    exp_err  = cp_error_i;
                end else wdly--;
            end else begin
                cp_resp_valid_i = ($urandom_range(0, 3) == 0);
            end

            cp_ready_i = ($urandom_range(0, 1) == 1);
            if (in_issue && cp_ready_i) begin
                in_issue = 0;
                in_wait  = 1;
                wdly     = $urandom_range(0, 8);
            end
        end
        step();
        req_valid_i     = 1'b0;
        cp_ready_i      = 1'b0;
        cp_resp_valid_i = 1'b0;
        rsp_ready_i     = 1'b0;
        n_checks++;
        if (cyc >= 3000) $display("FAIL rnd_drain: got undrained after %0d cycles want drained", cyc);
        else n_pass++;
        n_checks++;
        if (responded != accepted) $display("FAIL rnd_total: got %0d responses want %0d", responded, accepted);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        req_t r0 = rand_req();
        req_t r1 = rand_req();
        push_one(r0);
        push_one(r1);
        push_one(rand_req());
        n_checks++;
        if (cp_valid_o !== 1'b1) $display("FAIL arst_pre: got cpv%b want 1", cp_valid_o);
        else n_pass++;
        #2 rst_i = 1'b1;
        #1;
        n_checks++;
        if ({req_ready_o, cp_valid_o, rsp_valid_o, busy_o, count_o} !== {4'b1000, CW'(0)})
            $display("FAIL arst_ctrl: got rdy%b cpv%b rspv%b busy%b cnt%0d want 1 0 0 0 0",
                     req_ready_o, cp_valid_o, rsp_valid_o, busy_o, count_o);
        else n_pass++;
        n_checks++;
        if ({cp_funct_o, cp_op_a_o, cp_op_b_o, rsp_rd_o} !== '0)
            $display("FAIL arst_data: got %h %h %h %h want all zero", cp_funct_o, cp_op_a_o, cp_op_b_o, rsp_rd_o);
        else n_pass++;
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({cp_valid_o, rsp_valid_o, count_o} !== '0)
                $display("FAIL arst_quiet_%0d: got cpv%b rspv%b cnt%0d want 0 0 0", k, cp_valid_o, rsp_valid_o, count_o);
            else n_pass++;
        end
        push_one(r1);
        serve(r1, 32'h5555_AAAA, 1'b0, 2);
    endtask

    initial begin
        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_funct_i     = '0;
        req_op_a_i      = '0;
        req_op_b_i      = '0;
        req_rd_i        = '0;
        flush_i         = 1'b0;
        cp_ready_i      = 1'b0;
        cp_resp_valid_i = 1'b0;
        cp_result_i     = '0;
        cp_error_i      = 1'b0;
        rsp_ready_i     = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_rsp_hold();
        test_flush();
        test_timeout();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
